sprite_overlay_engine: RTL

//  Pipelined, animated sprite overlay for the VGA overlay path. Renders NUM_SPRITES copies of
//  the 48x45 lion bitmap (internal ROM) inside a bounding box. Sprites bounce off the box walls

---
 rtl/sprite_overlay_engine.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sprite_overlay_engine.sv
// Animated lion-sprite overlay for the VGA overlay path: bounce/blink animation per frame,
// two-stage pixel pipeline (hit/offset, then ROM lookup and priority) with 2-cycle latency.
module sprite_overlay_engine #(
    parameter int          NUM_SPRITES  = 3,
    parameter int          SPR_W        = 48,
    parameter int          SPR_H        = 45,
    parameter int          X_MIN        = 240,
    parameter int          X_MAX        = 400,
    parameter int          Y_MIN        = 144,
    parameter int          Y_MAX        = 320,
    parameter int          STEP         = 2,
    parameter int          BLINK_FRAMES = 32,
    parameter logic [5:0]  COLOR_FG     = 6'b100100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       frame_start,
    input  logic       anim_en,
    input  logic [1:0] mode,
    output logic       draw,
    output logic [5:0] rgb
);

    localparam int             CW       = $clog2(BLINK_FRAMES);
    localparam logic [CW-1:0]  HALF     = CW'(BLINK_FRAMES / 2);
    localparam logic [10:0]    X_MIN_W  = 11'(X_MIN);
    localparam logic [10:0]    X_MAX_W  = 11'(X_MAX);
    localparam logic [10:0]    Y_MIN_W  = 11'(Y_MIN);
    localparam logic [10:0]    Y_MAX_W  = 11'(Y_MAX);
    localparam logic [10:0]    STEP_W   = 11'(STEP);
    localparam logic [10:0]    SPR_W_W  = 11'(SPR_W);
    localparam logic [10:0]    SPR_H_W  = 11'(SPR_H);
    localparam logic [9:0]     STEP_P   = 10'(STEP);

    logic [9:0]             px [NUM_SPRITES];
    logic [9:0]             py [NUM_SPRITES];
    logic                   dir_left [NUM_SPRITES];
    logic                   dir_up [NUM_SPRITES];
    logic [CW-1:0]          blink_cnt;

    logic                   s1_active;
    logic                   s1_blank;
    logic [NUM_SPRITES-1:0] s1_hit;
    logic [5:0]             s1_col [NUM_SPRITES];
    logic [5:0]             s1_row [NUM_SPRITES];

    logic                   pix_on;
    logic [5:0]             pix_rgb;

    // 48x45 lion bitmap; bit 0 of each row word is the leftmost pixel.
    function automatic logic rom_bit(input logic [5:0] row, input logic [5:0] col);
        logic [47:0] w;
        case (row)
            6'd0:  w = 48'h000000000000;  6'd1:  w = 48'h00000FF00000;
            6'd2:  w = 48'h0000FFFF0000;  6'd3:  w = 48'h000FFFFFF000;
            6'd4:  w = 48'h003FFFFFFC00;  6'd5:  w = 48'h00FFFFFFFF00;
            6'd6:  w = 48'h03FFFFFFFFC0;  6'd7:  w = 48'h07FFFFFFFFE0;
            6'd8:  w = 48'h0FFFF00FFFF0;  6'd9:  w = 48'h1FFF0000FFF8;
            6'd10: w = 48'h1FFC3C3C3FF8;  6'd11: w = 48'h3FF87E7E1FFC;
            6'd12: w = 48'h3FF0FFFF0FFC;  6'd13: w = 48'h7FE3C3C3C7FE;
            6'd14: w = 48'h7FE3C3C3C7FE;  6'd15: w = 48'h7FE0FFFF07FE;
            6'd16: w = 48'h7FC07E7E03FE;  6'd17: w = 48'h7FC0FFFF03FE;
            6'd18: w = 48'h7FC1E7E783FE;  6'd19: w = 48'h7FC3FFFFC3FE;
            6'd20: w = 48'h3FC1FFFF83FC;  6'd21: w = 48'h3FE0FE7F07FC;
            6'd22: w = 48'h1FE07C3E07F8;  6'd23: w = 48'h1FF03C3C0FF8;
            6'd24: w = 48'h0FF81FF81FF0;  6'd25: w = 48'h07FC0FF03FE0;
            6'd26: w = 48'h03FF07E0FFC0;  6'd27: w = 48'h00FFC3C3FF00;
            6'd28: w = 48'h003FFFFFFC00;  6'd29: w = 48'h000FFFFFF000;
            6'd30: w = 48'h0003FFFFC000;  6'd31: w = 48'h00007FFE0000;
            6'd32: w = 48'h00003FFC0000;  6'd33: w = 48'h00007FFE0000;
            6'd34: w = 48'h0000FFFF0000;  6'd35: w = 48'h0001FFFF8000;
            6'd36: w = 48'h0003FFFFC000;  6'd37: w = 48'h0007FFFFE000;
            6'd38: w = 48'h000FFFFFF000;  6'd39: w = 48'h001FE7E7F800;
            6'd40: w = 48'h003FC3C3FC00;  6'd41: w = 48'h007F8181FE00;
            6'd42: w = 48'h00FF0000FF00;  6'd43: w = 48'h01FE00007F80;
            6'd44: w = 48'h8FC000003FC1;
            default: w = '0;
        endcase
        if (row >= 6'(SPR_H))
            w = '0;
        return w[col];
    endfunction

    // A wall hit flips direction and holds the position for that frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                px[i]       <= 10'(X_MIN + 8 + i * (SPR_W + 4));
                py[i]       <= 10'(Y_MIN + 16 + i * 32);
                dir_left[i] <= 1'((i % 2) == 1);
                dir_up[i]   <= 1'b0;
            end
        end else if (frame_start && anim_en) begin
            blink_cnt <= blink_cnt + CW'(1);
            if (mode[0]) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    if (!dir_left[i]) begin
                        if ({1'b0, px[i]} + STEP_W + SPR_W_W > X_MAX_W) dir_left[i] <= 1'b1;
                        else                                            px[i] <= px[i] + STEP_P;
                    end else begin
                        if ({1'b0, px[i]} < X_MIN_W + STEP_W) dir_left[i] <= 1'b0;
                        else                                  px[i] <= px[i] - STEP_P;
                    end
                    if (!dir_up[i]) begin
                        if ({1'b0, py[i]} + STEP_W + SPR_H_W > Y_MAX_W) dir_up[i] <= 1'b1;
                        else                                            py[i] <= py[i] + STEP_P;
                    end else begin
                        if ({1'b0, py[i]} < Y_MIN_W + STEP_W) dir_up[i] <= 1'b0;
                        else                                  py[i] <= py[i] - STEP_P;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_active <= 1'b0;
            s1_blank  <= 1'b0;
            s1_hit    <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                s1_col[i] <= '0;
                s1_row[i] <= '0;
            end
        end else begin
            s1_active <= active;
            s1_blank  <= mode[1] && (blink_cnt >= HALF);
            for (int i = 0; i < NUM_SPRITES; i++) begin
                s1_hit[i] <= ({1'b0, x} >= {1'b0, px[i]}) && ({1'b0, x} < {1'b0, px[i]} + SPR_W_W) &&
                             ({1'b0, y} >= {1'b0, py[i]}) && ({1'b0, y} < {1'b0, py[i]} + SPR_H_W);
                s1_col[i] <= 6'(x - px[i]);
                s1_row[i] <= 6'(y - py[i]);
            end
        end
    end

    // Scan from the highest index down so the lowest-index opaque sprite ends up on top.
    always_comb begin
        pix_on  = 1'b0;
        pix_rgb = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (s1_hit[i] && rom_bit(s1_row[i], s1_col[i])) begin
                pix_on  = 1'b1;
                pix_rgb = COLOR_FG;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            draw <= 1'b0;
            rgb  <= '0;
        end else begin
            draw <= s1_active && !s1_blank && pix_on;
            rgb  <= (s1_active && !s1_blank && pix_on) ? pix_rgb : 6'd0;
        end
    end

endmodule
